// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the multicycle LEGv8 main control FSM: states, opcodes,
// datapath select codes and opcode classes.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LD_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_CBZ_EX   = 4'd8,
    S_B_EX     = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CBZ matches on opcode[10:3], B on opcode[10:5]
  localparam logic [7:0] CBZ_PREFIX = 8'b10110100;
  localparam logic [5:0] B_PREFIX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_BTGT   = 2'b10;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LD  = 3'd1,
    CLS_ST  = 3'd2,
    CLS_CBZ = 3'd3,
    CLS_B   = 3'd4,
    CLS_ILL = 3'd5
  } op_class_t;

endpackage

// File: rtl/legv8_op_classify.sv
// Combinational IR[31:21] to instruction-class decoder; feeds both the
// DECODE/MEM_ADDR branching and the reg2loc select.
module legv8_op_classify
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  op_class
);

  always_comb begin
    op_class = CLS_ILL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      op_class = CLS_R;
    else if (opcode == OP_LDUR)
      op_class = CLS_LD;
    else if (opcode == OP_STUR)
      op_class = CLS_ST;
    else if (opcode[10:3] == CBZ_PREFIX)
      op_class = CLS_CBZ;
    else if (opcode[10:5] == B_PREFIX)
      op_class = CLS_B;
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath.
// Define PERF_CNT_EN to add the retired-instruction counter output retired_cnt.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR and PC+4 when memory is ready
// DECODE   | classify opcode, compute branch target into ALUOut
// MEM_ADDR | compute load/store effective address
// MEM_RD   | data read, wait for mem_ready
// LD_WB    | write MDR to register file
// MEM_WR   | data write, wait for mem_ready
// R_EXEC   | R-type ALU operation
// R_WB     | write ALU result to register file
// CBZ_EX   | compare Rt to zero, conditional PC load from ALUOut
// B_EX     | unconditional PC load from branch target
// TRAP     | illegal opcode seen, parked until reset
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
`ifdef PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg2loc,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic [3:0]  state
);

  state_t     state_q, state_d;
  logic [2:0] op_class;

  // zero gates pc_write_cond inside the datapath, not in this FSM
  logic unused_zero;
  assign unused_zero = zero;

  legv8_op_classify u_classify (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    reg2loc       = (state_q != S_FETCH) && (op_class == CLS_ST || op_class == CLS_CBZ);

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BR;
        case (op_class)
          CLS_R:         state_d = S_R_EXEC;
          CLS_LD, CLS_ST: state_d = S_MEM_ADDR;
          CLS_CBZ:       state_d = S_CBZ_EX;
          CLS_B:         state_d = S_B_EX;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_class == CLS_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_CBZ_EX: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_PASSB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_B_EX: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_BTGT;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        state_d    = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase

    // Hold every datapath strobe quiet while reset is asserted
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg2loc       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
    end
  end

  assign state = rst_n ? state_q : 4'd0;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  always_comb begin
    retire = (state_q == S_LD_WB) || (state_q == S_R_WB) || (state_q == S_CBZ_EX) ||
             (state_q == S_B_EX) || (state_q == S_MEM_WR && mem_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign retired_cnt = rst_n ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed self-checking bench for legv8_multicycle_ctrl; covers PERF_CNT_EN when defined.
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [10:0] opcode;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg2loc, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
`ifdef PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg2loc(reg2loc), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op),
`ifdef PERF_CNT_EN
    .retired_cnt(retired_cnt),
`endif
    .state(state)
  );

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg2loc,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
  logic [16:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg2loc,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  localparam logic [16:0] C_ZERO       = 17'b0;
  localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_MEM_ADDR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEM_RD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_LD_WB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_MEM_WR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_R_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_R_WB       = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_CBZ_EX     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_B_EX       = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_TRAP       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] R2L          = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_0;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (ctrl !== C_ZERO) begin n_bad++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_ZERO); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL release_state: got %0d expected 0", state); end
    n_cmp++; if (ctrl !== C_FETCH_WAIT) begin n_bad++; $display("FAIL release_ctrl: got %b expected %b", ctrl, C_FETCH_WAIT); end
  endtask

  task automatic test_reset_mid_wr();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic [16:0] ec [5] = '{C_FETCH_RDY, C_DECODE | R2L, C_MEM_ADDR | R2L, C_MEM_WR | R2L, C_MEM_WR | R2L};
    logic        mr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (i == 0) opcode = 11'b11111000000; mem_ready = mr[i]; #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL rstwr_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL rstwr_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
    end
    @(negedge clk); rst_n = 1'b0; #1;
    n_cmp++; if (ctrl !== C_ZERO) begin n_bad++; $display("FAIL rstwr_assert_ctrl: got %b expected %b", ctrl, C_ZERO); end
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL rstwr_assert_state: got %0d expected 0", state); end
    @(negedge clk); #1;
    n_cmp++; if (ctrl !== C_ZERO) begin n_bad++; $display("FAIL rstwr_held_ctrl: got %b expected %b", ctrl, C_ZERO); end
`ifdef PERF_CNT_EN
    n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL rstwr_cnt: got %0d expected 0", retired_cnt); end
`endif
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL rstwr_release_state: got %0d expected 0", state); end
    n_cmp++; if (ctrl !== C_FETCH_WAIT) begin n_bad++; $display("FAIL rstwr_release_ctrl: got %b expected %b", ctrl, C_FETCH_WAIT); end
  endtask

  task automatic test_add();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [16:0] ec [5] = '{C_FETCH_RDY, C_DECODE, C_R_EXEC, C_R_WB, C_FETCH_WAIT};
    logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (i == 0) opcode = 11'b10001011000; mem_ready = mr[i]; #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL add_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
    end
  endtask

  task automatic test_ldur();
    logic [3:0]  es [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [16:0] ec [9] = '{C_FETCH_RDY, C_DECODE, C_MEM_ADDR, C_MEM_RD, C_MEM_RD, C_MEM_RD,
                            C_MEM_RD, C_LD_WB, C_FETCH_WAIT};
    logic        mr [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); if (i == 0) opcode = 11'b11111000010; mem_ready = mr[i]; #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL ldur_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL ldur_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
    end
  endtask

  task automatic test_stur();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    logic [16:0] ec [6] = '{C_FETCH_RDY, C_DECODE | R2L, C_MEM_ADDR | R2L, C_MEM_WR | R2L,
                            C_MEM_WR | R2L, C_FETCH_WAIT};
    logic        mr [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (i == 0) opcode = 11'b11111000000; mem_ready = mr[i]; #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL stur_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL stur_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
    end
  endtask

  task automatic test_cbz();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [16:0] ec [4] = '{C_FETCH_RDY, C_DECODE | R2L, C_CBZ_EX | R2L, C_FETCH_WAIT};
    logic [10:0] ops [2] = '{11'b10110100101, 11'b10110100000};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) begin opcode = ops[k]; zero = (k == 0); end
        mem_ready = (i != 3); #1;
        n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL cbz%0d_state[%0d]: got %0d expected %0d", k, i, state, es[i]); end
        n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL cbz%0d_ctrl[%0d]: got %b expected %b", k, i, ctrl, ec[i]); end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_b();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    logic [16:0] ec [4] = '{C_FETCH_RDY, C_DECODE, C_B_EX, C_FETCH_WAIT};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (i == 0) opcode = 11'b00010111111; mem_ready = (i != 3); #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL b_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL b_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
    end
`ifdef PERF_CNT_EN
    // ADD, LDUR, STUR, two CBZ and B have retired since the mid-write reset
    n_cmp++; if (retired_cnt !== 32'd6) begin n_bad++; $display("FAIL retired_cnt: got %0d expected 6", retired_cnt); end
`endif
  endtask

  task automatic test_rtype_variants();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [16:0] ec [5] = '{C_FETCH_RDY, C_DECODE, C_R_EXEC, C_R_WB, C_FETCH_WAIT};
    logic [10:0] ops [3] = '{11'b11001011000, 11'b10001010000, 11'b10101010000};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); if (i == 0) opcode = ops[k]; mem_ready = (i != 4); #1;
        n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL rt%0d_state[%0d]: got %0d expected %0d", k, i, state, es[i]); end
        n_cmp++; if (ctrl !== ec[i]) begin n_bad++; $display("FAIL rt%0d_ctrl[%0d]: got %b expected %b", k, i, ctrl, ec[i]); end
      end
    end
  endtask

  task automatic test_trap();
    @(negedge clk); opcode = 11'b00000000000; mem_ready = 1'b1; #1;
    n_cmp++; if (ctrl !== C_FETCH_RDY) begin n_bad++; $display("FAIL trap_fetch_ctrl: got %b expected %b", ctrl, C_FETCH_RDY); end
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd1) begin n_bad++; $display("FAIL trap_decode_state: got %0d expected 1", state); end
    n_cmp++; if (ctrl !== C_DECODE) begin n_bad++; $display("FAIL trap_decode_ctrl: got %b expected %b", ctrl, C_DECODE); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); mem_ready = i[0]; #1;
      n_cmp++; if (state !== 4'd10) begin n_bad++; $display("FAIL trap_state[%0d]: got %0d expected 10", i, state); end
      n_cmp++; if (ctrl !== C_TRAP) begin n_bad++; $display("FAIL trap_ctrl[%0d]: got %b expected %b", i, ctrl, C_TRAP); end
    end
    @(negedge clk); rst_n = 1'b0; #1;
    n_cmp++; if (ctrl !== C_ZERO) begin n_bad++; $display("FAIL trap_rst_ctrl: got %b expected %b", ctrl, C_ZERO); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL trap_release_state: got %0d expected 0", state); end
    n_cmp++; if (ctrl !== C_FETCH_WAIT) begin n_bad++; $display("FAIL trap_release_ctrl: got %b expected %b", ctrl, C_FETCH_WAIT); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 11'b0;
    test_reset();
    test_reset_mid_wr();
    test_add();
    test_ldur();
    test_stur();
    test_cbz();
    test_b();
    test_rtype_variants();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
